// File: rtl/bicubic_window_fetch_if.sv
//============================================================================
// bicubic_window_fetch_if : request, bank-read and window bus of the fetcher
// Revision: 1.0
//============================================================================
`default_nettype none

interface bicubic_window_fetch_if #(
  parameter int PIX_W = 8
);
  logic signed [31:0]  rows;
  logic signed [31:0]  cols;
  logic signed [31:0]  pixels_loaded;
  logic                req_valid;
  logic                req_ready;
  logic signed [31:0]  req_x;
  logic signed [31:0]  req_y;
  logic [3:0]          rd_en;
  logic signed [31:0]  rd_addr [0:3];
  logic [PIX_W-1:0]    rd_data [0:3];
  logic                out_valid;
  logic                out_ready;
  logic [16*PIX_W-1:0] win;
  logic signed [31:0]  out_x;
  logic signed [31:0]  out_y;

  modport master (
    output rows, cols, pixels_loaded, req_valid, req_x, req_y, rd_data, out_ready,
    input  req_ready, rd_en, rd_addr, out_valid, win, out_x, out_y
  );

  modport slave (
    input  rows, cols, pixels_loaded, req_valid, req_x, req_y, rd_data, out_ready,
    output req_ready, rd_en, rd_addr, out_valid, win, out_x, out_y
  );
endinterface

`default_nettype wire

// File: rtl/bicubic_window_fetch.sv
//============================================================================
// bicubic_window_fetch : 4x4 edge-clamped window fetch from a 4-bank buffer
// Optional macro WINDOW_ZERO_PAD_EN zeroes out-of-image taps.  Revision: 1.0
//============================================================================
`default_nettype none

module bicubic_window_fetch #(
  parameter int PIX_W      = 8,
  parameter int RD_LATENCY = 1
) (
  input wire                    clock,
  input wire                    reset,
  bicubic_window_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [1:0]          drain_q, drain_d;
  logic signed [31:0]  x_q, y_q;
  logic [16*PIX_W-1:0] win_q;

  // Per-read tag travelling alongside the bank latency: valid, row, lane offset
  logic                pv_q   [RD_LATENCY];
  logic [1:0]          prow_q [RD_LATENCY];
  logic [1:0]          poff_q [RD_LATENCY];

  logic signed [31:0]  cr [4];
  logic signed [31:0]  cc [4];
  logic [1:0]          elem [4];
  logic signed [31:0]  s_col, last_idx, base_idx;
  logic [1:0]          off;
  logic [1:0]          sel [4];
  logic [PIX_W-1:0]    cap_pix [4];
  logic signed [31:0]  cap_r, cap_c;

  function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    logic signed [31:0] r;
    r = v;
    if (v > hi) r = hi;
    if (v < lo) r = lo;
    return r;
  endfunction

  always_comb begin
    s_col = clamp(x_q - 32'sd1, 32'sd0, bus.cols - 32'sd4);
    for (int i = 0; i < 4; i++) begin
      cr[i]   = clamp(y_q + i - 32'sd1, 32'sd0, bus.rows - 32'sd1);
      cc[i]   = clamp(x_q + i - 32'sd1, 32'sd0, bus.cols - 32'sd1);
      elem[i] = 2'(cc[i] - s_col);
    end
    last_idx = cr[3] * bus.cols + s_col + 32'sd3;
    base_idx = cr[row_q] * bus.cols + s_col;
    off      = base_idx[1:0];
  end

  // Banks below the start lane hold the tail of the run in the next word
  always_comb begin
    bus.rd_en = 4'b0000;
    for (int k = 0; k < 4; k++) bus.rd_addr[k] = 32'sd0;
    if (state_q == S_READ) begin
      bus.rd_en = 4'b1111;
      for (int k = 0; k < 4; k++)
        bus.rd_addr[k] = (base_idx >>> 2) + ((2'(k) < off) ? 32'sd1 : 32'sd0);
    end
  end

  always_comb begin
    cap_r = y_q + $signed({30'b0, prow_q[RD_LATENCY-1]}) - 32'sd1;
    cap_c = 32'sd0;
    for (int j = 0; j < 4; j++) begin
      sel[j]     = poff_q[RD_LATENCY-1] + elem[j];
      cap_pix[j] = bus.rd_data[sel[j]];
      cap_c      = x_q + j - 32'sd1;
`ifdef WINDOW_ZERO_PAD_EN
      if (cap_r < 32'sd0 || cap_r >= bus.rows || cap_c < 32'sd0 || cap_c >= bus.cols)
        cap_pix[j] = '0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_CHECK;
      S_CHECK: if (last_idx <= bus.pixels_loaded) begin
                 state_d = S_READ;
                 row_d   = 2'd0;
               end
      S_READ:  begin
                 row_d = row_q + 2'd1;
                 if (row_q == 2'd3) begin
                   state_d = S_DRAIN;
                   drain_d = 2'd0;
                 end
               end
      S_DRAIN: begin
                 drain_d = drain_q + 2'd1;
                 if (drain_q == 2'(RD_LATENCY - 1)) state_d = S_OUT;
               end
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 2'd0;
      drain_q <= 2'd0;
      x_q     <= 32'sd0;
      y_q     <= 32'sd0;
      win_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pv_q[k]   <= 1'b0;
        prow_q[k] <= 2'd0;
        poff_q[k] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      if (state_q == S_IDLE && bus.req_valid) begin
        x_q <= bus.req_x;
        y_q <= bus.req_y;
      end
      pv_q[0]   <= (state_q == S_READ);
      prow_q[0] <= row_q;
      poff_q[0] <= off;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        prow_q[k] <= prow_q[k-1];
        poff_q[k] <= poff_q[k-1];
      end
      if (pv_q[RD_LATENCY-1]) begin
        for (int j = 0; j < 4; j++)
          win_q[(4 * int'(prow_q[RD_LATENCY-1]) + j) * PIX_W +: PIX_W] <= cap_pix[j];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.win       = win_q;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;

endmodule

`default_nettype wire

// File: tb/tb_bicubic_window_fetch.sv
//============================================================================
// tb_bicubic_window_fetch : vector table + scoreboard bench for the fetcher
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_bicubic_window_fetch;
  localparam int PIX_W = 8;
  localparam int RDL   = 1;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;

  typedef struct {
    int           x;
    int           y;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    int           x;
    int           y;
    logic [127:0] win;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];

  always #5 clock = ~clock;

  bicubic_window_fetch_if #(.PIX_W(PIX_W)) bus ();

  bicubic_window_fetch #(.PIX_W(PIX_W), .RD_LATENCY(RDL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Bank model: bank k, word a holds pixel 4a+k whose value is its index & 0xFF
  logic [7:0] m1 [4];
  logic [7:0] m2 [4];
  always @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      m1[k] <= bus.rd_en[k] ? 8'((4 * bus.rd_addr[k] + k) & 255) : 8'hEE;
      m2[k] <= m1[k];
    end
  end
  always_comb begin
    for (int k = 0; k < 4; k++) bus.rd_data[k] = (RDL == 1) ? m1[k] : m2[k];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference window straight from 2-D image coordinates
  function automatic logic [127:0] ref_win(int x, int y);
    logic [127:0] w;
    logic [7:0]   p;
    int           r, c;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = y - 1 + i;
        c = x - 1 + j;
        p = 8'((clampi(r, 0, ROWS - 1) * COLS + clampi(c, 0, COLS - 1)) & 255);
`ifdef WINDOW_ZERO_PAD_EN
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) p = 8'd0;
`endif
        w[(4 * i + j) * 8 +: 8] = p;
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] row4(int r, int a, int b, int c, int d);
    logic [127:0] v;
    v = {96'b0, 8'(d), 8'(c), 8'(b), 8'(a)};
    return v << (32 * r);
  endfunction

  function automatic vec_t mkvec(int x, int y, int hold, logic [127:0] exp);
    vec_t v;
    v.x = x; v.y = y; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("win", bus.win, e.win);
      chk("out_x", bus.out_x, e.x);
      chk("out_y", bus.out_y, e.y);
    end
  endtask

  task automatic run_vec(input int x, input int y, input int hold,
                         input logic [127:0] exp, input bit chk_addr);
    int                 n;
    bit                 got, stable;
    logic [127:0]       w0;
    logic signed [31:0] y0;
    logic signed [31:0] a0 [4];
    sb.push_back(exp_t'{x, y, exp});
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    // n counts clock edges including the accept edge
    n   = 1;
    got = 1'b0;
    for (int k = 0; k < 4; k++) a0[k] = -1;
    while (!bus.out_valid && n < 100) begin
      if (!got && bus.rd_en == 4'hF) begin
        got = 1'b1;
        for (int k = 0; k < 4; k++) a0[k] = bus.rd_addr[k];
      end
      @(negedge clock);
      n++;
    end
    chk("latency", n, 1 + 4 + RDL + 1);
    if (chk_addr)
      chk("rd_addr_row0", {a0[0], a0[1], a0[2], a0[3]}, {32'sd5, 32'sd5, 32'sd4, 32'sd4});
    w0     = bus.win;
    y0     = bus.out_y;
    stable = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      if (bus.win !== w0 || bus.out_y !== y0 || bus.req_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    if (hold > 0) chk("backpressure_hold", stable, 1);
    bus.out_ready = 1'b1;
    pop_compare();
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("release", {bus.out_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    vec_t vecs [6];
    int   n;
    bit   ok;

    vecs[0] = mkvec(3, 3, 0, row4(0, 18, 19, 20, 21) | row4(1, 26, 27, 28, 29) |
                             row4(2, 34, 35, 36, 37) | row4(3, 42, 43, 44, 45));
`ifdef WINDOW_ZERO_PAD_EN
    vecs[1] = mkvec(0, 0, 2, row4(1, 0, 0, 1, 2) | row4(2, 0, 8, 9, 10) |
                             row4(3, 0, 16, 17, 18));
    vecs[2] = mkvec(7, 3, 10, row4(0, 22, 23, 0, 0) | row4(1, 30, 31, 0, 0) |
                              row4(2, 38, 39, 0, 0) | row4(3, 46, 47, 0, 0));
`else
    vecs[1] = mkvec(0, 0, 2, row4(0, 0, 0, 1, 2) | row4(1, 0, 0, 1, 2) |
                             row4(2, 8, 8, 9, 10) | row4(3, 16, 16, 17, 18));
    vecs[2] = mkvec(7, 3, 10, row4(0, 22, 23, 23, 23) | row4(1, 30, 31, 31, 31) |
                              row4(2, 38, 39, 39, 39) | row4(3, 46, 47, 47, 47));
`endif
    vecs[3] = mkvec(7, 7, 0, ref_win(7, 7));
    vecs[4] = mkvec(2, 6, 1, ref_win(2, 6));
    vecs[5] = mkvec(4, 0, 3, ref_win(4, 0));

    bus.rows          = ROWS;
    bus.cols          = COLS;
    bus.pixels_loaded = 63;
    bus.req_valid     = 1'b0;
    bus.req_x         = 0;
    bus.req_y         = 0;
    bus.out_ready     = 1'b0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_ctrl", {bus.req_ready, bus.out_valid, bus.rd_en}, 6'b100000);
    chk("reset_addr", {bus.rd_addr[0], bus.rd_addr[1], bus.rd_addr[2], bus.rd_addr[3]}, 0);
    chk("reset_win", bus.win, 0);
    chk("reset_xy", {bus.out_x, bus.out_y}, 0);

    for (int v = 0; v < 6; v++)
      run_vec(vecs[v].x, vecs[v].y, vecs[v].hold, vecs[v].exp, v == 0);

    // Fill stall: needs pixel 45 before any read may start
    bus.pixels_loaded = 31;
    sb.push_back(exp_t'{3, 3, vecs[0].exp});
    bus.req_x     = 3;
    bus.req_y     = 3;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (bus.rd_en !== 4'h0 || bus.req_ready !== 1'b0 || bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("stall_at_31", ok, 1);
    bus.pixels_loaded = 44;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (bus.rd_en !== 4'h0 || bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("stall_at_44", ok, 1);
    bus.pixels_loaded = 45;
    @(negedge clock);
    chk("read_after_45", bus.rd_en, 4'hF);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("stall_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    pop_compare();
    @(negedge clock);
    bus.out_ready     = 1'b0;
    bus.pixels_loaded = 63;

    // Reset while reads are in flight
    bus.req_x     = 4;
    bus.req_y     = 4;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rd_en !== 4'hF && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("reached_read", bus.rd_en, 4'hF);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_ctrl", {bus.req_ready, bus.out_valid, bus.rd_en}, 6'b100000);
    chk("midrst_addr", {bus.rd_addr[0], bus.rd_addr[1], bus.rd_addr[2], bus.rd_addr[3]}, 0);
    chk("midrst_win", bus.win, 0);
    chk("midrst_xy", {bus.out_x, bus.out_y}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", {bus.req_ready, bus.out_valid}, 2'b10);
    chk("post_reset_win", bus.win, 0);

    run_vec(5, 5, 0, ref_win(5, 5), 1'b0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bicubic_window_fetch.md
Name: bicubic_window_fetch

Overview:
- Downstream consumer of the 4-bank pixel buffer. The buffer stores 4 pixels per word: byte k goes to bank k at the same address, so pixel index p = 4*addr + k.
- Accepts one output-coordinate request at a time and reads the 4x4 source neighbourhood (rows y-1..y+2, cols x-1..x+2) from the four banks, one image row per read cycle.
- Presents the 16 pixels as one flattened window to the bicubic interpolation datapath.
- Stalls until the buffer writer's fill pointer shows that every needed pixel has been written.

Parameters:
- PIX_W, 8, pixel width in bits.
- RD_LATENCY, 1, bank read latency in cycles; legal values are 1 and 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- rows  in  32 signed  source image height; must be >= 1
- cols  in  32 signed  source image width; must be >= 4
- pixels_loaded  in  32 signed  index of the last written pixel; -1 means nothing written yet
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_x  in  32 signed  source column, 0..cols-1
- req_y  in  32 signed  source row, 0..rows-1
- rd_en  out  4  per-bank read enable
- rd_addr[0:3]  out  32 signed  per-bank read address
- rd_data[0:3]  in  PIX_W  per-bank read data, valid RD_LATENCY cycles after rd_en
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts the window
- win  out  16*PIX_W  win[(4*i+j)*PIX_W +: PIX_W] = row i (y-1+i), col j (x-1+j)
- out_x, out_y  out  32 signed each  echo of the request

Behaviour:
- Reset values: req_ready=1, out_valid=0, rd_en=0, rd_addr[*]=0, win=0, out_x=0, out_y=0, state=IDLE. Reset mid-operation aborts the transaction immediately; read data still in flight is discarded.
- Request capture: a request is accepted on a clock edge where req_valid and req_ready are both high. req_x and req_y are registered at that edge.
- States: IDLE -> CHECK -> READ (4 cycles) -> DRAIN (RD_LATENCY cycles) -> OUT -> IDLE.
- Row clamping: cr[i] = clamp(y-1+i, 0, rows-1).
- Column clamping: cc[j] = clamp(x-1+j, 0, cols-1).
- Fetch start column: s = clamp(x-1, 0, cols-4). The four contiguous columns s..s+3 always cover every cc[j].
- CHECK: compute last = cr[3]*cols + s + 3.
  - Go to READ when last <= pixels_loaded (signed compare); otherwise stay in CHECK.
  - pixels_loaded is re-evaluated every cycle, so the stall has no timeout.
- READ cycle i (i = 0..3):
  - Base index b_i = cr[i]*cols + s; A = b_i >> 2; off = b_i & 3.
  - Bank k: rd_addr[k] = A + (k < off ? 1 : 0), and rd_en = 4'b1111.
  - rd_en is deasserted in every other state.
- Data alignment: the pixel from bank (off+m)&3 is contiguous element m (column s+m). Window column j takes element cc[j]-s.
- Capture: row i is captured RD_LATENCY cycles after its read cycle.
- Latency: minimum from accept edge to out_valid is 1 + 4 + RD_LATENCY + 1 cycles, i.e. 7 with RD_LATENCY=1, when no stall occurs.
- OUT: win, out_x and out_y are held stable while out_valid is high. The window is released on out_valid & out_ready. One transaction is in flight at a time.
- Arithmetic: index products use 32-bit signed arithmetic. Overflow is out of scope: rows*cols must be < 2^31.
- Illegal requests (x or y outside the image): behaviour is undefined, but the block must still return to IDLE.

Optional Feature:
- Macro: WINDOW_ZERO_PAD_EN.
  - Defined: neighbours whose unclamped row or column falls outside the image are output as 0 instead of the replicated edge pixel. Reads, addressing and the availability check are unchanged.
  - Undefined: edge replication as specified above.

Test Plan:
- Common setup: cols=8, rows=8, pixel value = index & 0xFF, pixels_loaded=63.
- Interior: req (3,3).
  - Row 0 read: banks 0,1 addr 5; banks 2,3 addr 4.
  - win rows = {18..21}, {26..29}, {34..37}, {42..45}; out_valid 7 cycles after accept.
- Top-left corner: req (0,0).
  - Without the macro: rows {0,0,1,2}, {0,0,1,2}, {8,8,9,10}, {16,16,17,18}.
  - With WINDOW_ZERO_PAD_EN: row 0 all 0, col 0 all 0.
- Right edge: req (7,3).
  - s=4; row 0 = {22,23,23,23}; row 3 = {46,47,47,47}.
- Fill stall: pixels_loaded=31, req (3,3).
  - Block holds in CHECK with rd_en=0.
  - Raise pixels_loaded to 44: still stalled. Raise to 45: reads start the next cycle.
- Backpressure and reset:
  - out_ready held low for 10 cycles: win and out_y stay stable, req_ready=0.
  - Assert reset during READ: all outputs return to reset values and req_ready=1 after release.
